// File: rtl/rotor_stepper.sv
// rotor_stepper: front stage of the Enigma datapath.
//
// Accepts one ASCII key per handshake, advances the left/middle/right rotor
// positions with Enigma double-stepping, and presents the key as a 26-bit
// one-hot vector. The vector is pre-rotated by the new right-rotor position and
// feeds the right rotor's f_in.
//
// Build option:
//   ENIGMA_LOWERCASE_EN  when defined, 'a'..'z' are accepted and mapped to
//                        'A'..'Z'. Otherwise they are rejected like any other
//                        non-letter.
//
// Parameters:
//   NOTCH_R    ASCII turnover letter of the right rotor (default "V", rotor III)
//   NOTCH_M    ASCII turnover letter of the middle rotor (default "E", rotor II)
//   NOTCH_L    ASCII turnover letter of the left rotor (default "Q", rotor I).
//              It has no stepping effect and is only range-checked here.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   load        in   load start positions from load_pos (honoured in IDLE only)
//   load_pos    in   {L[14:10], M[9:5], R[4:0]}, 0..25 = A..Z; >25 loads 0
//   key_valid   in   key_char valid
//   key_char    in   ASCII key
//   key_ready   out  stepper can accept a key (IDLE and not loading)
//   key_err     out  1-cycle pulse: accepted key was not a letter
//   out_valid   out  out_onehot valid
//   out_ready   in   downstream consumes out_onehot
//   out_onehot  out  bit ((letter + pos_r) mod 26) set
//   pos_l/m/r   out  current rotor positions, 0..25

module rotor_stepper #(
  parameter logic [7:0] NOTCH_R = 8'h56,
  parameter logic [7:0] NOTCH_M = 8'h45,
  parameter logic [7:0] NOTCH_L = 8'h51
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [14:0] load_pos,
  input  logic        key_valid,
  input  logic [7:0]  key_char,
  output logic        key_ready,
  output logic        key_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [25:0] out_onehot,
  output logic [4:0]  pos_l,
  output logic [4:0]  pos_m,
  output logic [4:0]  pos_r
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StStep = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  localparam logic [4:0] NotchRIdx = 5'(NOTCH_R - 8'h41);
  localparam logic [4:0] NotchMIdx = 5'(NOTCH_M - 8'h41);

  // Reject notch letters outside 'A'..'Z' at elaboration time.
  if (NOTCH_R < 8'h41 || NOTCH_R > 8'h5a || NOTCH_M < 8'h41 || NOTCH_M > 8'h5a ||
      NOTCH_L < 8'h41 || NOTCH_L > 8'h5a) begin : g_bad_notch
    $error("rotor_stepper: notch parameters must be ASCII 'A'..'Z'");
  end

  function automatic logic [4:0] step_pos(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  function automatic logic [4:0] clamp_pos(input logic [4:0] p);
    return (p > 5'd25) ? 5'd0 : p;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [4:0]  pos_l_q, pos_l_d;
  logic [4:0]  pos_m_q, pos_m_d;
  logic [4:0]  pos_r_q, pos_r_d;
  logic [4:0]  idx_q, idx_d;
  logic        key_err_q, key_err_d;
  logic        out_valid_q, out_valid_d;
  logic [25:0] out_onehot_q, out_onehot_d;

  // Key decode
  logic       is_upper;
  logic       is_letter;
  logic [4:0] letter_idx;

  assign is_upper = (key_char >= 8'h41) && (key_char <= 8'h5a);

`ifdef ENIGMA_LOWERCASE_EN
  logic is_lower;
  assign is_lower   = (key_char >= 8'h61) && (key_char <= 8'h7a);
  assign is_letter  = is_upper || is_lower;
  assign letter_idx = is_upper ? 5'(key_char - 8'h41) : 5'(key_char - 8'h61);
`else
  assign is_letter  = is_upper;
  assign letter_idx = 5'(key_char - 8'h41);
`endif

  // Stepping, all from pre-step positions
  logic       mid_turn;
  logic       right_turn;
  logic [4:0] new_r;
  logic [5:0] sum_raw;
  logic [4:0] onehot_idx;

  assign mid_turn   = (pos_m_q == NotchMIdx);
  assign right_turn = (pos_r_q == NotchRIdx);
  assign new_r      = step_pos(pos_r_q);
  // idx and new_r are both <= 25, so one conditional subtract brings the sum into range.
  assign sum_raw    = {1'b0, idx_q} + {1'b0, new_r};
  assign onehot_idx = (sum_raw >= 6'd26) ? 5'(sum_raw - 6'd26) : sum_raw[4:0];

  always_comb begin
    state_d      = state_q;
    pos_l_d      = pos_l_q;
    pos_m_d      = pos_m_q;
    pos_r_d      = pos_r_q;
    idx_d        = idx_q;
    key_err_d    = 1'b0;
    out_valid_d  = out_valid_q;
    out_onehot_d = out_onehot_q;
    case (state_q)
      StIdle: begin
        if (load) begin
          pos_l_d = clamp_pos(load_pos[14:10]);
          pos_m_d = clamp_pos(load_pos[9:5]);
          pos_r_d = clamp_pos(load_pos[4:0]);
        end else if (key_valid) begin
          if (is_letter) begin
            idx_d   = letter_idx;
            state_d = StStep;
          end else begin
            key_err_d = 1'b1;
          end
        end
      end
      StStep: begin
        pos_r_d = new_r;
        // Middle rotor double-steps: it moves on its own notch as well as on
        // the right rotor's.
        if (right_turn || mid_turn) pos_m_d = step_pos(pos_m_q);
        if (mid_turn) pos_l_d = step_pos(pos_l_q);
        out_onehot_d = 26'd1 << onehot_idx;
        out_valid_d  = 1'b1;
        state_d      = StOut;
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d  = 1'b0;
          out_onehot_d = '0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pos_l_q      <= '0;
      pos_m_q      <= '0;
      pos_r_q      <= '0;
      idx_q        <= '0;
      key_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_onehot_q <= '0;
    end else begin
      state_q      <= state_d;
      pos_l_q      <= pos_l_d;
      pos_m_q      <= pos_m_d;
      pos_r_q      <= pos_r_d;
      idx_q        <= idx_d;
      key_err_q    <= key_err_d;
      out_valid_q  <= out_valid_d;
      out_onehot_q <= out_onehot_d;
    end
  end

  // Held low during reset so nothing is taken while the block is being cleared.
  assign key_ready  = (state_q == StIdle) && !load && !reset;
  assign key_err    = key_err_q;
  assign out_valid  = out_valid_q;
  assign out_onehot = out_onehot_q;
  assign pos_l      = pos_l_q;
  assign pos_m      = pos_m_q;
  assign pos_r      = pos_r_q;

endmodule
